// File: rtl/lane_array.sv
// SIMD-style accumulator lane array with shared global registers and a
// serial readout port that shifts one lane's accumulator out LSB first.
module lane_array #(
    parameter int unsigned NR_LANES    = 4,
    parameter int unsigned BIT_WIDTH   = 8,
    parameter int unsigned GLOBAL_REGS = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] opcode,
    input  logic        execute,
    output logic        ready,
    output logic        valid_bit,
    output logic        output_bit,
    output logic        last_bit
);

    localparam int unsigned CNT_W = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [BIT_WIDTH-1:0] acc_q [NR_LANES];
    logic [BIT_WIDTH-1:0] acc_d [NR_LANES];
    logic [BIT_WIDTH-1:0] g_q   [GLOBAL_REGS];
    logic [BIT_WIDTH-1:0] g_d   [GLOBAL_REGS];
    logic [NR_LANES-1:0]  en_q, en_d;
    logic [0:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_WIDTH-1:0] sr_q, sr_d;
    logic                 valid_d, obit_d, last_d;

    logic                 accept;
    logic [1:0]           op_cls;
    logic [3:0]           fld;
    logic [3:0]           gidx;
    logic [BIT_WIDTH-1:0] imm;
    logic [BIT_WIDTH-1:0] g_sel;
    logic [BIT_WIDTH-1:0] store_val;
    logic                 store_hit;
    logic [BIT_WIDTH-1:0] snap;
    logic                 unused_opcode;

    assign op_cls        = opcode[15:14];
    assign fld           = opcode[12:9];
    assign gidx          = opcode[3:0];
    assign imm           = BIT_WIDTH'(opcode[7:0]);
    assign unused_opcode = ^{opcode[13], opcode[8]};

    assign ready  = (state_q == S_IDLE);
    assign accept = execute & ready;

    // Operand selection: unimplemented globals read as zero, out-of-range lanes snapshot zero
    always_comb begin
        g_sel     = '0;
        store_val = '0;
        store_hit = 1'b0;
        snap      = '0;
        for (int i = 0; i < GLOBAL_REGS; i++) begin
            if (gidx == 4'(i)) g_sel = g_q[i];
        end
        for (int i = NR_LANES - 1; i >= 0; i--) begin
            if (en_q[i]) begin
                store_hit = 1'b1;
                store_val = acc_q[i];
            end
        end
        for (int i = 0; i < NR_LANES; i++) begin
            if (fld == 4'(i)) snap = acc_q[i];
        end
    end

    // Next-state: instruction execution in IDLE, serial shifting in SHIFT
    always_comb begin
        acc_d   = acc_q;
        g_d     = g_q;
        en_d    = en_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        valid_d = valid_bit;
        obit_d  = output_bit;
        last_d  = last_bit;

        if (state_q == S_IDLE) begin
            if (accept) begin
                case (op_cls)
                    2'b00: begin
                        for (int i = 0; i < NR_LANES; i++)
                            if (en_q[i]) acc_d[i] = imm;
                    end
                    2'b01: begin
                        for (int i = 0; i < NR_LANES; i++)
                            if (en_q[i]) acc_d[i] = acc_q[i] + g_sel;
                    end
                    2'b10: begin
                        for (int i = 0; i < NR_LANES; i++)
                            if (en_q[i]) acc_d[i] = acc_q[i] - g_sel;
                    end
                    default: begin
                        if (opcode[7] && store_hit) begin
                            for (int i = 0; i < GLOBAL_REGS; i++)
                                if (fld == 4'(i)) g_d[i] = store_val;
                        end
                        case (opcode[6:5])
                            2'b01: begin
                                for (int i = 0; i < NR_LANES; i++)
                                    en_d[i] = (fld == 4'(i));
                            end
                            2'b10:   en_d = '1;
                            2'b11:   en_d = '0;
                            default: en_d = en_q;
                        endcase
                        if (opcode[4]) begin
                            state_d = S_SHIFT;
                            cnt_d   = '0;
                            sr_d    = snap >> 1;
                            valid_d = 1'b1;
                            obit_d  = snap[0];
                            last_d  = (BIT_WIDTH == 1);
                        end
                    end
                endcase
            end
        end else begin
            if (cnt_q == CNT_W'(BIT_WIDTH - 1)) begin
                state_d = S_IDLE;
                cnt_d   = '0;
                valid_d = 1'b0;
                obit_d  = 1'b0;
                last_d  = 1'b0;
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
                obit_d  = sr_q[0];
                sr_d    = sr_q >> 1;
                last_d  = (cnt_q == CNT_W'(BIT_WIDTH - 2));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NR_LANES; i++) acc_q[i] <= '0;
            for (int i = 0; i < GLOBAL_REGS; i++) g_q[i] <= '0;
            en_q       <= '1;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            valid_bit  <= 1'b0;
            output_bit <= 1'b0;
            last_bit   <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            g_q        <= g_d;
            en_q       <= en_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            valid_bit  <= valid_d;
            output_bit <= obit_d;
            last_bit   <= last_d;
        end
    end

endmodule
